button_conditioner: RTL and testbench
=====================================

# button_conditioner

Multi-channel successor to `button_parser` for the `z1top` input path. It synchronises `WIDTH` raw push-button or switch inputs into `clk` and debounces each channel symmetrically on both press and release, using one shared sample tick. For each channel it reports the debounced level plus one-cycle press, release and long-press pulses. Each channel can optionally auto-repeat its press pulse while held. It sits between the board pins and consumers such as the reset logic, CPU MMIO and LEDs.

## Interface
Parameters:
- `WIDTH`, 4: number of independent channels.
- `SAMPLE_CNT_MAX`, 35714: clock cycles per sample tick (500 us at the CPU clock); must be ≥ 2.
- `PULSE_CNT_MAX`, 200: consecutive disagreeing samples required to flip the debounced level; must be ≥ 1.
- `LONG_CNT_MAX`, 2000: sample ticks of continuous debounced press before `long_press` fires; must be ≥ 1.
- `REPEAT_CNT_MAX`, 200: sample ticks between auto-repeat `press` pulses; must be ≥ 1.
- `ACTIVE_LOW`, 0: 1 means raw `in` is low when pressed; it is inverted before the synchroniser.

Ports:
- `clk`, in, 1: single clock; all state is on the rising edge.
- `rst_n`, in, 1: reset is asynchronous and active-low.
- `in`, in, `WIDTH`: raw asynchronous inputs.
- `repeat_en`, in, `WIDTH`: per-channel auto-repeat enable; synchronous to `clk` and read at sample ticks.
- `level`, out, `WIDTH`: debounced pressed state.
- `press`, out, `WIDTH`: one-cycle pulse on debounced press and on each auto-repeat.
- `release`, out, `WIDTH`: one-cycle pulse on debounced release.
- `long_press`, out, `WIDTH`: one-cycle pulse once per hold, after `LONG_CNT_MAX` ticks.

## Operation
- **Reset.** All counters, synchroniser flops and states are cleared. `level`, `press`, `release` and `long_press` are all 0. Asserting `rst_n` mid-operation aborts any debounce or hold immediately, with no pulse emitted.
- **Synchroniser.** The polarity-corrected input feeds a 2-flop synchroniser per channel; both flops reset to 0 (not pressed). This adds 2 cycles of latency.
- **Sample tick.**
  - One shared counter `0..SAMPLE_CNT_MAX-1`, width `$clog2(SAMPLE_CNT_MAX)`.
  - `tick` is high for exactly one cycle when the count equals `SAMPLE_CNT_MAX-1`; the counter then wraps to 0.
  - The first tick occurs `SAMPLE_CNT_MAX` cycles after reset release.
- **Debounce (per channel), evaluated on tick only.**
  - If `sync == level`, clear `db_cnt`.
  - Otherwise increment `db_cnt`. When it reaches `PULSE_CNT_MAX`, toggle `level` and clear `db_cnt`.
  - A single agreeing sample restarts the count, so glitches shorter than `PULSE_CNT_MAX` ticks are rejected in both directions.
- **Hold FSM (per channel)**, states `RELEASED`, `PRESSED`, `HELD`; a tick-qualified `hold_cnt` is shared by `PRESSED` and `HELD`:
  - `RELEASED` → `PRESSED` when `level` rises: pulse `press`, clear `hold_cnt`.
  - In `PRESSED`, increment `hold_cnt` each tick. When it reaches `LONG_CNT_MAX`: pulse `long_press`, clear `hold_cnt`, go to `HELD`.
  - In `HELD` with `repeat_en[i]`=1, increment `hold_cnt` each tick. When it reaches `REPEAT_CNT_MAX`: pulse `press`, clear `hold_cnt`.
  - In `HELD` with `repeat_en[i]`=0, hold `hold_cnt` at 0.
  - From `PRESSED` or `HELD`, go to `RELEASED` when `level` falls: pulse `release`, clear `hold_cnt`.
- **Simultaneous events.**
  - A `level` fall on the same tick that `long_press` or a repeat would fire: `release` wins, and no `long_press` or `press` is emitted.
  - Channels are fully independent; any combination of channels may pulse in the same cycle.
- **Counters.** All counters saturate-safe: they are cleared before overflow. Widths are `$clog2(MAX+1)` of their respective parameters.

## Timing
- All outputs are registered and change only in the tick cycle. `press`, `release` and `long_press` are high for exactly one `clk` cycle.
- **Press latency** from a stable raw edge to `level`/`press`: from `2 + (PULSE_CNT_MAX-1)·SAMPLE_CNT_MAX + 1` to `2 + PULSE_CNT_MAX·SAMPLE_CNT_MAX` cycles. Release latency has the same bounds.
- `long_press` fires exactly `LONG_CNT_MAX·SAMPLE_CNT_MAX` cycles after the `press` pulse.
- Repeat pulses are spaced exactly `REPEAT_CNT_MAX·SAMPLE_CNT_MAX` cycles apart. The first repeat follows `long_press` by the same interval.
- `level` and the `press`/`release` pulse for a given edge assert in the same cycle.

## Test plan
All scenarios use `SAMPLE_CNT_MAX`=4, `PULSE_CNT_MAX`=3, `LONG_CNT_MAX`=5, `REPEAT_CNT_MAX`=2, `WIDTH`=4 unless stated.
- **Reset.** Hold `rst_n`=0 with `in`=4'hF, then release → all outputs 0; first tick occurs 4 cycles later; `level[0]`=1 no later than 2+12 cycles after release.
- **Glitch rejection.** Pulse `in[1]` high for 2 ticks, low for 1, high for 2 → `level[1]` stays 0 and no pulses appear. Then hold it high for 3 ticks → one `press[1]` cycle with `level[1]`=1.
- **Long press and repeat.** Hold `in[2]` with `repeat_en[2]`=1 → `press` at T, `long_press` at T+20, `press` at T+28 and T+36. Release → single `release` pulse, no further `press`. With `repeat_en[2]`=0 → no repeats.
- **Active-low and release priority.** Set `ACTIVE_LOW`=1 and drive `in[3]`=0 (pressed) → press pulse. Schedule the raw release so `level` falls on the tick where `long_press` would fire → `release` only, `long_press[3]` never asserts.
- **Multi-channel and reset mid-hold.** Press ch0 and ch1 in the same cycle → simultaneous `press` bits 2'b11. Assert `rst_n`=0 mid-hold → `level` goes 0 asynchronously with no `release` pulse. After reset release with inputs still high → fresh press pulses after debounce.

Source files
------------

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: 2-flop sync, symmetric debounce on a shared
// sample tick, and per-channel press / release / long-press / auto-repeat pulses.

module button_conditioner_lane #(
    parameter int PULSE_CNT_MAX  = 200,
    parameter int LONG_CNT_MAX   = 2000,
    parameter int REPEAT_CNT_MAX = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press
);
    localparam int DBW      = $clog2(PULSE_CNT_MAX + 1);
    localparam int HOLD_MAX = (LONG_CNT_MAX > REPEAT_CNT_MAX) ? LONG_CNT_MAX : REPEAT_CNT_MAX;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {RELEASED, PRESSED, HELD} state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d, rel_q, rel_d, long_q, long_d;
    logic [DBW-1:0]   db_cnt_q, db_cnt_d, db_inc;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d, hold_inc;
    logic             toggle;

    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        level_d    = level_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        state_d    = state_q;
        press_d    = 1'b0;
        rel_d      = 1'b0;
        long_d     = 1'b0;
        toggle     = 1'b0;
        db_inc     = db_cnt_q + 1'b1;
        hold_inc   = hold_cnt_q + 1'b1;

        if (tick) begin
            if (sync2_q == level_q) begin
                db_cnt_d = '0;
            end else if (db_inc == DBW'(PULSE_CNT_MAX)) begin
                db_cnt_d = '0;
                level_d  = ~level_q;
                toggle   = 1'b1;
            end else begin
                db_cnt_d = db_inc;
            end

            // A level change on this tick takes priority over any hold-timer pulse.
            case (state_q)
                RELEASED: begin
                    if (toggle) begin
                        state_d    = PRESSED;
                        hold_cnt_d = '0;
                        press_d    = 1'b1;
                    end
                end
                PRESSED: begin
                    if (toggle) begin
                        state_d    = RELEASED;
                        hold_cnt_d = '0;
                        rel_d      = 1'b1;
                    end else if (hold_inc == HW'(LONG_CNT_MAX)) begin
                        state_d    = HELD;
                        hold_cnt_d = '0;
                        long_d     = 1'b1;
                    end else begin
                        hold_cnt_d = hold_inc;
                    end
                end
                HELD: begin
                    if (toggle) begin
                        state_d    = RELEASED;
                        hold_cnt_d = '0;
                        rel_d      = 1'b1;
                    end else if (!repeat_en) begin
                        hold_cnt_d = '0;
                    end else if (hold_inc == HW'(REPEAT_CNT_MAX)) begin
                        hold_cnt_d = '0;
                        press_d    = 1'b1;
                    end else begin
                        hold_cnt_d = hold_inc;
                    end
                end
                default: begin
                    state_d    = RELEASED;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RELEASED;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            long_q     <= long_d;
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = rel_q;
    assign long_press    = long_q;
endmodule

module button_conditioner #(
    parameter int WIDTH          = 4,
    parameter int SAMPLE_CNT_MAX = 35714,
    parameter int PULSE_CNT_MAX  = 200,
    parameter int LONG_CNT_MAX   = 2000,
    parameter int REPEAT_CNT_MAX = 200,
    parameter int ACTIVE_LOW     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] repeat_en,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_press
);
    localparam int SW = $clog2(SAMPLE_CNT_MAX);

    logic [SW-1:0]    smp_cnt_q, smp_cnt_d;
    logic             tick;
    logic [WIDTH-1:0] in_pc;

    assign in_pc = (ACTIVE_LOW != 0) ? ~in : in;

    always_comb begin
        tick      = (smp_cnt_q == SW'(SAMPLE_CNT_MAX - 1));
        smp_cnt_d = tick ? '0 : smp_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) smp_cnt_q <= '0;
        else        smp_cnt_q <= smp_cnt_d;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        button_conditioner_lane #(
            .PULSE_CNT_MAX (PULSE_CNT_MAX),
            .LONG_CNT_MAX  (LONG_CNT_MAX),
            .REPEAT_CNT_MAX(REPEAT_CNT_MAX)
        ) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .tick         (tick),
            .raw          (in_pc[i]),
            .repeat_en    (repeat_en[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .long_press   (long_press[i])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: level vector table plus a pulse scoreboard keyed by cycle.

module tb_button_conditioner;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in, in_al, repeat_en;
    logic [3:0] level, press, rls, lng;
    logic [3:0] level_al, press_al, rls_al, lng_al;

    always #5 clk = ~clk;

    button_conditioner #(.WIDTH(4), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3),
                         .LONG_CNT_MAX(5), .REPEAT_CNT_MAX(2), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .repeat_en(repeat_en),
        .level(level), .press(press), .release_pulse(rls), .long_press(lng));

    button_conditioner #(.WIDTH(4), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3),
                         .LONG_CNT_MAX(5), .REPEAT_CNT_MAX(2), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst_n(rst_n), .in(in_al), .repeat_en(repeat_en),
        .level(level_al), .press(press_al), .release_pulse(rls_al), .long_press(lng_al));

    // Cycles since reset release; sample ticks land on edges where cyc % 4 == 0.
    int cyc;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int cyc; int kind; int d; int ch; } ev_t;
    ev_t exp_q[$];

    typedef struct { logic [3:0] in; logic [3:0] lvl; logic [3:0] prs; logic [3:0] rl; } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    // kind: 0 press, 1 release, 2 long_press
    task automatic push(input int c, input int k, input int d, input logic [3:0] mask);
        for (int i = 0; i < 4; i++)
            if (mask[i]) begin
                ev_t e;
                e.cyc = c; e.kind = k; e.d = d; e.ch = i;
                exp_q.push_back(e);
            end
    endtask

    task automatic obs(input int d, input int k, input logic [3:0] v);
        for (int ch = 0; ch < 4; ch++)
            if (v[ch]) begin
                int hit = -1;
                for (int i = 0; i < exp_q.size(); i++)
                    if (exp_q[i].cyc == cyc && exp_q[i].kind == k &&
                        exp_q[i].d == d && exp_q[i].ch == ch) hit = i;
                checks++;
                if (hit < 0) begin
                    errors++;
                    $display("FAIL pulse dut%0d kind%0d ch%0d: got pulse at cyc %0d, required none",
                             d, k, ch, cyc);
                end else begin
                    exp_q.delete(hit);
                end
            end
    endtask

    always @(negedge clk)
        if (rst_n) begin
            obs(0, 0, press);    obs(0, 1, rls);    obs(0, 2, lng);
            obs(1, 0, press_al); obs(1, 1, rls_al); obs(1, 2, lng_al);
        end

    task automatic drain();
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing dut%0d kind%0d ch%0d: got no pulse, required one at cyc %0d",
                         exp_q[i].d, exp_q[i].kind, exp_q[i].ch, exp_q[i].cyc);
                exp_q.delete(i);
            end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic goto_tick();
        do begin
            @(posedge clk); #1;
        end while (cyc % 4 != 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, t;
        logic [3:0] prev;
        tbl[0] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
        tbl[1] = '{4'b0110, 4'b0110, 4'b0110, 4'b0001};
        tbl[2] = '{4'b1001, 4'b1001, 4'b1001, 4'b0110};
        tbl[3] = '{4'b0100, 4'b0100, 4'b0100, 4'b1001};
        tbl[4] = '{4'b1010, 4'b1010, 4'b1010, 4'b0100};
        tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b1010};
        tbl[6] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000};
        tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111};

        // Reset with all inputs pressed
        rst_n = 1'b0; in = 4'hF; in_al = 4'hF; repeat_en = 4'h0;
        #23;
        @(negedge clk) rst_n = 1'b1;
        push(12, 0, 0, 4'hF);
        #1;
        chk("rst_level", level, 0);
        chk("rst_press", press, 0);
        chk("rst_release", rls, 0);
        chk("rst_long", lng, 0);
        chk("rst_level_al", level_al, 0);
        wait_until(11); chk("rst_level_pre", level, 4'h0);
        wait_until(12); chk("rst_level_post", level, 4'hF);
        wait_until(16); in = 4'h0; push(28, 1, 0, 4'hF);
        wait_until(30); drain();

        // Vector table: one vector per 16 cycles, latency boundary at +11/+12
        prev = 4'h0;
        for (int v = 0; v < 8; v++) begin
            goto_tick();
            e = cyc;
            in = tbl[v].in;
            push(e + 12, 0, 0, tbl[v].prs);
            push(e + 12, 1, 0, tbl[v].rl);
            wait_until(e + 11); chk($sformatf("tbl%0d_lvl_pre", v), level, prev);
            wait_until(e + 12); chk($sformatf("tbl%0d_lvl", v), level, tbl[v].lvl);
            prev = tbl[v].lvl;
        end
        wait_until(cyc + 4); drain();

        // Glitch rejection on ch1: 2 high, 1 low, 2 high, 1 low, then 3 high
        goto_tick(); e = cyc;
        in[1] = 1'b1;
        wait_until(e + 8);  in[1] = 1'b0;
        wait_until(e + 12); in[1] = 1'b1;
        wait_until(e + 20); in[1] = 1'b0;
        wait_until(e + 24); in[1] = 1'b1;
        push(e + 36, 0, 0, 4'b0010);
        wait_until(e + 35); chk("glitch_lvl_low", level, 4'b0000);
        wait_until(e + 36); chk("glitch_lvl_high", level, 4'b0010);
        in[1] = 1'b0; push(e + 48, 1, 0, 4'b0010);
        wait_until(e + 52); drain();

        // Long press and repeat on ch2; release lands on a would-be repeat tick
        repeat_en = 4'b0100;
        goto_tick(); e = cyc; t = e + 12;
        in[2] = 1'b1;
        push(t, 0, 0, 4'b0100);
        push(t + 20, 2, 0, 4'b0100);
        push(t + 28, 0, 0, 4'b0100);
        push(t + 36, 0, 0, 4'b0100);
        push(t + 44, 0, 0, 4'b0100);
        wait_until(t + 40); in[2] = 1'b0;
        push(t + 52, 1, 0, 4'b0100);
        wait_until(t + 51); chk("rep_lvl_held", level, 4'b0100);
        wait_until(t + 70); drain();

        // Same hold without repeat enabled
        repeat_en = 4'b0000;
        goto_tick(); e = cyc; t = e + 12;
        in[2] = 1'b1;
        push(t, 0, 0, 4'b0100);
        push(t + 20, 2, 0, 4'b0100);
        wait_until(t + 48); in[2] = 1'b0;
        push(t + 60, 1, 0, 4'b0100);
        wait_until(t + 64); drain();

        // Active-low ch3; level falls on the tick long_press would fire
        goto_tick(); e = cyc; t = e + 12;
        in_al[3] = 1'b0;
        push(t, 0, 1, 4'b1000);
        wait_until(t + 8); in_al[3] = 1'b1;
        push(t + 20, 1, 1, 4'b1000);
        wait_until(t);      chk("al_lvl_press", level_al, 4'b1000);
        wait_until(t + 19); chk("al_lvl_pre", level_al, 4'b1000);
        wait_until(t + 20); chk("al_lvl_fall", level_al, 4'b0000);
        wait_until(t + 48); drain();

        // Two channels together, then reset mid-hold
        goto_tick(); e = cyc;
        in[1:0] = 2'b11;
        push(e + 12, 0, 0, 4'b0011);
        wait_until(e + 12); chk("multi_press", press, 4'b0011);
        wait_until(e + 17); drain();
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_level", level, 4'b0000);
        chk("midrst_release", rls, 4'b0000);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        push(12, 0, 0, 4'b0011);
        wait_until(12); chk("rerst_press", press, 4'b0011);
        wait_until(16); in = 4'h0; push(28, 1, 0, 4'b0011);
        wait_until(40); drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
